// File: rtl/cdc_upsizer_pkg.sv
// Shared types and helpers for the source-side CDC width upconverter.
// Holds the control FSM encoding and the contiguous lane-strobe helper.
package cdc_upsizer_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SEND     = 2'd1,
        CLR_REQ  = 2'd2,
        CLR_WAIT = 2'd3
    } upsizer_state_e;

    localparam int unsigned MAX_RATIO = 32;

    // Strobe with lanes 0..idx set; idx must be below MAX_RATIO.
    function automatic logic [MAX_RATIO-1:0] lane_mask(input int unsigned idx);
        return {MAX_RATIO{1'b1}} >> (MAX_RATIO - 1 - idx);
    endfunction

endpackage

// File: rtl/cdc_src_upsizer.sv
// Packs up to RATIO narrow beats into one strobed wide word for the CDC FIFO source port and sequences clears.
// Latency: word valid the cycle after its closing beat; no combinational in->out path (one bubble per word).
// Backpressure: input stalls while a word waits for out_ready_i and for the whole clear sequence.
module cdc_src_upsizer
    import cdc_upsizer_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned RATIO    = 4
) (
    input  logic                      src_clk_i,
    input  logic                      src_rst_ni,
    input  logic                      clear_i,
    input  logic [IN_WIDTH-1:0]       in_data_i,
    input  logic                      in_last_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [IN_WIDTH*RATIO-1:0] out_data_o,
    output logic [RATIO-1:0]          out_strb_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      fifo_clear_o,
    input  logic                      fifo_clear_pending_i,
    output logic                      clear_busy_o
);

    localparam int unsigned IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (RATIO < 2 || IN_WIDTH < 1 || RATIO > MAX_RATIO) begin : g_param_check
        $error("cdc_src_upsizer: need RATIO in 2..MAX_RATIO and IN_WIDTH >= 1");
    end

    upsizer_state_e                   state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [RATIO-1:0][IN_WIDTH-1:0]   data_q, data_d;
    logic [RATIO-1:0]                 strb_q, strb_d;
    logic                             clr_q, clr_d;
    logic [MAX_RATIO-1:0]             mask_full;

    assign mask_full = lane_mask(32'(idx_q));

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        clr_d   = 1'b0;
        unique case (state_q)
            FILL: begin
                // Clear wins over a same-cycle beat: the beat is taken and thrown away.
                if (clear_i) begin
                    state_d = CLR_REQ;
                    clr_d   = 1'b1;
                    idx_d   = '0;
                    data_d  = '0;
                    strb_d  = '0;
                end else if (fifo_clear_pending_i) begin
                    state_d = CLR_WAIT;
                    idx_d   = '0;
                    data_d  = '0;
                    strb_d  = '0;
                end else if (in_valid_i) begin
                    data_d[idx_q] = in_data_i;
                    strb_d        = mask_full[RATIO-1:0];
                    if (idx_q == LAST_IDX || in_last_i) begin
                        state_d = SEND;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SEND: begin
                // A handshake coinciding with clear_i has already delivered the word.
                if (clear_i) begin
                    state_d = CLR_REQ;
                    clr_d   = 1'b1;
                    data_d  = '0;
                    strb_d  = '0;
                end else if (fifo_clear_pending_i) begin
                    state_d = CLR_WAIT;
                    data_d  = '0;
                    strb_d  = '0;
                end else if (out_ready_i) begin
                    state_d = FILL;
                    data_d  = '0;
                    strb_d  = '0;
                end
            end
            CLR_REQ: begin
                if (fifo_clear_pending_i) begin
                    state_d = CLR_WAIT;
                end
            end
            CLR_WAIT: begin
                if (!fifo_clear_pending_i) begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
                data_d  = '0;
                strb_d  = '0;
            end
        endcase
    end

    assign in_ready_o   = (state_q == FILL);
    assign out_valid_o  = (state_q == SEND);
    assign clear_busy_o = (state_q == CLR_REQ) || (state_q == CLR_WAIT);
    assign fifo_clear_o = clr_q;
    assign out_data_o   = data_q;
    assign out_strb_o   = strb_q;

`ifndef SYNTHESIS
    // Withdrawal under a local or remote clear is legal; the FIFO isolates its source port.
    a_out_stable: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        (out_valid_o && !out_ready_i && !clear_i && !fifo_clear_pending_i)
        |=> ($stable(out_data_o) && $stable(out_strb_o)));

    a_strb_contig: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        out_valid_o |-> (out_strb_o[0] && ((out_strb_o & (out_strb_o + RATIO'(1))) == '0)));

    a_clear_pulse: assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        fifo_clear_o |=> !fifo_clear_o);
`endif

endmodule
